// File: rtl/tft_timing_gen.sv
// DE-mode TFT timing generator with backlight PWM.
// Divides the system clock down to a pixel clock, walks (x,y) over the frame,
// registers host RGB onto the panel bus and drives the syncs, enables and backlight.
module tft_timing_gen #(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned H_FP     = 2,
    parameter int unsigned H_PULSE  = 41,
    parameter int unsigned H_BP     = 2,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned V_FP     = 2,
    parameter int unsigned V_PULSE  = 10,
    parameter int unsigned V_BP     = 2,
    parameter int unsigned CLK_DIV  = 10,
    parameter int unsigned CW       = 8,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PWM_DIV  = 20
) (
    input  logic                clk,
    input  logic                reset_btn,
    input  logic                display_on,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic [3*CW-1:0]     rgb_in,
    output logic [10:0]         pix_x,
    output logic [9:0]          pix_y,
    output logic                pix_req,
    output logic                frame_start,
    output logic                tft_clk,
    output logic                tft_de,
    output logic                tft_hsync_n,
    output logic                tft_vsync_n,
    output logic [CW-1:0]       tft_r,
    output logic [CW-1:0]       tft_g,
    output logic [CW-1:0]       tft_b,
    output logic                tft_en,
    output logic                tft_display,
    output logic                led_en
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_PULSE + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_PULSE + V_BP;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] H_PS      = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_PE      = 11'(H_ACTIVE + H_FP + H_PULSE);
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE);
    localparam logic [9:0]  V_PS      = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_PE      = 10'(V_ACTIVE + V_FP + V_PULSE);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);

    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

    // Timing state
    logic               en_q, en_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [10:0]        h_q, h_d;
    logic [9:0]         v_q, v_d;
    logic               clk_q, clk_d;
    logic               de_q, de_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic [3*CW-1:0]    rgb_q, rgb_d;
    logic               fs_q, fs_d;

    // Backlight state
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [PWM_BITS-1:0] bri_q, bri_d;
    logic                led_q, led_d;

    logic active, pix_en, h_wrap, v_wrap, h_pulse, v_pulse, pwm_step;

    assign active   = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    assign pix_en   = en_q && (div_q == DIV_LAST);
    assign h_wrap   = (h_q == H_LAST);
    assign v_wrap   = (v_q == V_LAST);
    assign h_pulse  = (h_q >= H_PS) && (h_q < H_PE);
    assign v_pulse  = (v_q >= V_PS) && (v_q < V_PE);
    assign pwm_step = (pre_q == PRE_LAST);

    // Next-state for pixel clock, counters and panel outputs
    always_comb begin
        en_d  = en_q;
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        clk_d = clk_q;
        de_d  = de_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        rgb_d = rgb_q;
        fs_d  = 1'b0;
        if (!display_on) begin
            // Sleep: everything parks at zero so wake-up starts a fresh frame
            en_d  = 1'b0;
            div_d = '0;
            h_d   = '0;
            v_d   = '0;
            clk_d = 1'b0;
            de_d  = 1'b0;
            hs_d  = 1'b0;
            vs_d  = 1'b0;
            rgb_d = '0;
        end else begin
            en_d = 1'b1;
            // Counting begins the clk after tft_en rises
            if (en_q) begin
                if (div_q == DIV_HALF) begin
                    clk_d = 1'b1;
                end
                if (pix_en) begin
                    // Outputs reflect the current counters, then the counters advance
                    clk_d = 1'b0;
                    div_d = '0;
                    de_d  = active;
                    rgb_d = active ? rgb_in : '0;
                    hs_d  = !h_pulse;
                    vs_d  = !v_pulse;
                    if (h_wrap) begin
                        h_d = '0;
                        if (v_wrap) begin
                            v_d  = '0;
                            fs_d = 1'b1;
                        end else begin
                            v_d = v_q + 10'd1;
                        end
                    end else begin
                        h_d = h_q + 11'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        end
    end

    // Next-state for backlight prescaler, PWM counter and brightness latch
    always_comb begin
        pre_d = pwm_step ? '0 : pre_q + PRE_W'(1);
        pwm_d = pwm_step ? pwm_q + PWM_BITS'(1) : pwm_q;
        bri_d = bri_q;
        // Latch only at the period boundary so a mid-period change never glitches
        if (pwm_step && (&pwm_q)) begin
            bri_d = brightness;
        end
        led_d = display_on && ((&bri_q) || (pwm_q < bri_q));
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset_btn) begin
            en_q  <= 1'b0;
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            clk_q <= 1'b0;
            de_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            rgb_q <= '0;
            fs_q  <= 1'b0;
            pre_q <= '0;
            pwm_q <= '0;
            bri_q <= '0;
            led_q <= 1'b0;
        end else begin
            en_q  <= en_d;
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            clk_q <= clk_d;
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
            fs_q  <= fs_d;
            pre_q <= pre_d;
            pwm_q <= pwm_d;
            bri_q <= bri_d;
            led_q <= led_d;
        end
    end

    assign pix_x       = h_q;
    assign pix_y       = v_q;
    assign pix_req     = en_q && active;
    assign frame_start = fs_q;
    assign tft_clk     = clk_q;
    assign tft_de      = de_q;
    assign tft_hsync_n = hs_q;
    assign tft_vsync_n = vs_q;
    assign tft_r       = rgb_q[3*CW-1:2*CW];
    assign tft_g       = rgb_q[2*CW-1:CW];
    assign tft_b       = rgb_q[CW-1:0];
    assign tft_en      = en_q;
    assign tft_display = en_q;
    assign led_en      = led_q;

endmodule

// File: tb/tb_tft_timing_gen.sv
// Directed bench for tft_timing_gen with a 7x6 pixel frame and a 2-clk pixel period.
module tb_tft_timing_gen;

    logic        clk;
    logic        reset_btn;
    logic        display_on;
    logic [1:0]  brightness;
    logic [23:0] rgb_in;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        pix_req;
    logic        frame_start;
    logic        tft_clk;
    logic        tft_de;
    logic        tft_hsync_n;
    logic        tft_vsync_n;
    logic [7:0]  tft_r;
    logic [7:0]  tft_g;
    logic [7:0]  tft_b;
    logic        tft_en;
    logic        tft_display;
    logic        led_en;

    int n_total = 0;
    int n_pass  = 0;

    tft_timing_gen #(
        .H_ACTIVE (4),
        .H_FP     (1),
        .H_PULSE  (1),
        .H_BP     (1),
        .V_ACTIVE (3),
        .V_FP     (1),
        .V_PULSE  (1),
        .V_BP     (1),
        .CLK_DIV  (2),
        .CW       (8),
        .PWM_BITS (2),
        .PWM_DIV  (1)
    ) dut (
        .clk         (clk),
        .reset_btn   (reset_btn),
        .display_on  (display_on),
        .brightness  (brightness),
        .rgb_in      (rgb_in),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_req     (pix_req),
        .frame_start (frame_start),
        .tft_clk     (tft_clk),
        .tft_de      (tft_de),
        .tft_hsync_n (tft_hsync_n),
        .tft_vsync_n (tft_vsync_n),
        .tft_r       (tft_r),
        .tft_g       (tft_g),
        .tft_b       (tft_b),
        .tft_en      (tft_en),
        .tft_display (tft_display),
        .led_en      (led_en)
    );

    // Host returns {x, y, 0} for the requested pixel
    assign rgb_in = {pix_x[7:0], pix_y[7:0], 8'h00};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // Advance one clk; sample on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset or sleep: every output low
    task automatic check_off(input string tag);
        chk({tag, ".pix_x"}, pix_x, 0);
        chk({tag, ".pix_y"}, pix_y, 0);
        chk({tag, ".pix_req"}, pix_req, 0);
        chk({tag, ".frame_start"}, frame_start, 0);
        chk({tag, ".tft_clk"}, tft_clk, 0);
        chk({tag, ".tft_de"}, tft_de, 0);
        chk({tag, ".hsync_n"}, tft_hsync_n, 0);
        chk({tag, ".vsync_n"}, tft_vsync_n, 0);
        chk({tag, ".tft_r"}, tft_r, 0);
        chk({tag, ".tft_g"}, tft_g, 0);
        chk({tag, ".tft_b"}, tft_b, 0);
        chk({tag, ".tft_en"}, tft_en, 0);
        chk({tag, ".tft_display"}, tft_display, 0);
        chk({tag, ".led_en"}, led_en, 0);
    endtask

    // Expected outputs n clk edges after the first running edge (brightness 0)
    task automatic check_cycle(input int n);
        int p, h, v, q, qh, qv;
        logic req, de, hs, vs;
        p   = n / 2;
        h   = p % 7;
        v   = (p / 7) % 6;
        req = (h < 4) && (v < 3);
        if (n >= 2) begin
            q  = n / 2 - 1;
            qh = q % 7;
            qv = (q / 7) % 6;
            de = (qh < 4) && (qv < 3);
            hs = (qh != 5);
            vs = (qv != 4);
        end else begin
            qh = 0;
            qv = 0;
            de = 1'b0;
            hs = 1'b0;
            vs = 1'b0;
        end
        chk($sformatf("pix_x@%0d", n), pix_x, h);
        chk($sformatf("pix_y@%0d", n), pix_y, v);
        chk($sformatf("pix_req@%0d", n), pix_req, req);
        chk($sformatf("tft_de@%0d", n), tft_de, de);
        chk($sformatf("tft_r@%0d", n), tft_r, de ? qh : 0);
        chk($sformatf("tft_g@%0d", n), tft_g, de ? qv : 0);
        chk($sformatf("tft_b@%0d", n), tft_b, 0);
        chk($sformatf("hsync_n@%0d", n), tft_hsync_n, hs);
        chk($sformatf("vsync_n@%0d", n), tft_vsync_n, vs);
        chk($sformatf("tft_clk@%0d", n), tft_clk, n % 2);
        chk($sformatf("frame_start@%0d", n), frame_start, (n > 0) && (n % 84 == 0));
        chk($sformatf("tft_en@%0d", n), tft_en, 1);
        chk($sformatf("tft_display@%0d", n), tft_display, 1);
        chk($sformatf("led_en@%0d", n), led_en, 0);
    endtask

    logic [27:0] exp_led;

    initial begin
        reset_btn  = 1'b1;
        display_on = 1'b1;
        brightness = 2'd0;
        step();
        step();
        check_off("reset");

        // Two full frames from reset
        reset_btn = 1'b0;
        for (int n = 0; n <= 175; n++) begin
            step();
            check_cycle(n);
        end

        // Restart, run to (2,1), then reset mid-line
        reset_btn = 1'b1;
        step();
        reset_btn = 1'b0;
        for (int n = 0; n <= 18; n++) begin
            step();
            check_cycle(n);
        end
        reset_btn = 1'b1;
        step();
        check_off("midline_reset");
        reset_btn = 1'b0;
        for (int n = 0; n <= 50; n++) begin
            step();
            check_cycle(n);
        end

        // Sleep mid-frame, then wake and expect a frame_start 84 clks later
        display_on = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_off("sleep");
        end
        display_on = 1'b1;
        for (int n = 0; n <= 90; n++) begin
            step();
            check_cycle(n);
        end

        // PWM: brightness 1, changed to 2 mid-period, then 3, then 0
        exp_led    = 28'b0000_0000_1111_1111_0011_0001_0000;
        reset_btn  = 1'b1;
        brightness = 2'd1;
        step();
        reset_btn = 1'b0;
        for (int k = 0; k < 28; k++) begin
            if (k < 6)       brightness = 2'd1;
            else if (k < 10) brightness = 2'd2;
            else if (k < 18) brightness = 2'd3;
            else             brightness = 2'd0;
            step();
            chk($sformatf("pwm.led_en@%0d", k), led_en, exp_led[k]);
        end

        // Full brightness, then sleep kills the backlight on the next clk
        brightness = 2'd3;
        for (int i = 0; i < 8; i++) step();
        chk("full.led_en", led_en, 1);
        display_on = 1'b0;
        step();
        chk("sleep.led_en", led_en, 0);
        chk("sleep.tft_en", tft_en, 0);
        chk("sleep.tft_display", tft_display, 0);
        chk("sleep.tft_de", tft_de, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
